// File: rtl/vram_scan_arbiter_if.sv
// rtl/vram_scan_arbiter_if.sv - writer request/acknowledge bus into the VRAM scan arbiter
//
// Signals:
//   wr_req   writer request, held with wr_addr/wr_data until wr_ack
//   wr_addr  cell address, row*COLS+col
//   wr_data  character code
//   wr_ack   1-cycle pulse when the request has been taken into the write buffer
// Modports: master = game-logic writer, slave = arbiter.

interface vram_scan_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/vram_scan_arbiter.sv
// rtl/vram_scan_arbiter.sv - single-port character VRAM shared by VGA scan-out and a game-logic writer
//
// Display fetch always wins the RAM port; writes pass through a 1-entry buffer drained into
// free cycles. Optional clear-screen sweep compiled in with `define VRAM_CLEAR_EN.
//
// Ports:
//   pclk, reset_n           pixel clock, asynchronous active-low reset
//   h_addr, v_addr, valid   active-area pixel position and flag from VGA timing
//   wr (slave modport)      wr_req/wr_addr/wr_data in, wr_ack out
//   clr_req                 start clear sweep (pulse)
//   clr_busy, clr_done      clear pending/in progress, pulse after last clear write
//   ram_addr/ram_we/ram_wdata/ram_rdata   synchronous VRAM port (read data one cycle later)
//   char_code, cell_px, cell_py, char_valid   glyph-stage outputs, 2 cycles behind h/v/valid

module vram_scan_arbiter #(
    parameter int              COLS     = 80,
    parameter int              ROWS     = 30,
    parameter int              ADDR_W   = 12,
    parameter int              DATA_W   = 8,
    parameter logic [DATA_W-1:0] CLR_CHAR = 8'h20
) (
    input  logic                pclk,
    input  logic                reset_n,
    input  logic [9:0]          h_addr,
    input  logic [9:0]          v_addr,
    input  logic                valid,
    vram_scan_arbiter_if.slave  wr,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [DATA_W-1:0]   char_code,
    output logic [2:0]          cell_px,
    output logic [3:0]          cell_py,
    output logic                char_valid
);

    // One extra bit so the bound still works when COLS*ROWS == 2**ADDR_W.
    localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(COLS*ROWS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_WAIT = 2'd1,
        CLEAR    = 2'd2
    } state_t;

    state_t              state;

    logic                disp_slot;
    logic [ADDR_W-1:0]   disp_addr;

    logic                buf_valid;
    logic [ADDR_W-1:0]   buf_addr;
    logic [DATA_W-1:0]   buf_data;
    logic                ack_q;
    logic                drain;
    logic                capture;

    logic                clr_wr;
    logic [ADDR_W-1:0]   clr_cnt;

    logic                slot_d1;
    logic [2:0]          px_d1;
    logic [3:0]          py_d1;
    logic                vld_d1;

    logic                unused_bits;

    assign unused_bits = v_addr[9];

    // Scan-out fetch: first pixel of every cell in the active area.
    assign disp_slot = valid && (h_addr[2:0] == 3'd0);
    assign disp_addr = ADDR_W'(v_addr[8:4]) * ADDR_W'(COLS) + ADDR_W'(h_addr[9:3]);

    assign drain = buf_valid && !disp_slot;

    // ack_q blocks a second capture while the writer still holds the acked request.
    // A buffer draining this cycle may be refilled in the same cycle.
    assign capture = wr.wr_req && !ack_q && (state == IDLE) && (!buf_valid || drain);

    assign wr.wr_ack = ack_q;

    // RAM port: display > buffer drain > clear write.
    always_comb begin
        ram_addr  = disp_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_slot) begin
            ram_addr = disp_addr;
        end else if (buf_valid) begin
            ram_addr  = buf_addr;
            ram_we    = 1'b1;
            ram_wdata = buf_data;
        end else if (clr_wr) begin
            ram_addr  = clr_cnt;
            ram_we    = 1'b1;
            ram_wdata = CLR_CHAR;
        end
    end

    // Write buffer. Out-of-range addresses are acknowledged but never marked valid.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= capture;
            if (capture) begin
                buf_valid <= ({1'b0, wr.wr_addr} < CELLS);
                buf_addr  <= wr.wr_addr;
                buf_data  <= wr.wr_data;
            end else if (drain) begin
                buf_valid <= 1'b0;
            end
        end
    end

    // Scan pipeline: stage 1 is the RAM read cycle, stage 2 presents the character.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            slot_d1    <= 1'b0;
            px_d1      <= '0;
            py_d1      <= '0;
            vld_d1     <= 1'b0;
            cell_px    <= '0;
            cell_py    <= '0;
            char_valid <= 1'b0;
            char_code  <= '0;
        end else begin
            slot_d1    <= disp_slot;
            px_d1      <= h_addr[2:0];
            py_d1      <= v_addr[3:0];
            vld_d1     <= valid;
            cell_px    <= px_d1;
            cell_py    <= py_d1;
            char_valid <= vld_d1;
            if (slot_d1) begin
                char_code <= ram_rdata;
            end
        end
    end

`ifdef VRAM_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS*ROWS - 1);

    state_t state_nxt;
    logic   clr_done_q;

    // The buffer is always empty in CLEAR (no captures outside IDLE); the term keeps the
    // priority explicit.
    assign clr_wr   = (state == CLEAR) && !disp_slot && !buf_valid;
    assign clr_busy = (state != IDLE);
    assign clr_done = clr_done_q;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_done_q <= clr_wr && (clr_cnt == LAST_CELL);
            if (state != CLEAR) begin
                clr_cnt <= '0;
            end else if (clr_wr) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (clr_req)    state_nxt = CLR_WAIT;
            CLR_WAIT: if (!buf_valid) state_nxt = CLEAR;
            CLEAR:    if (clr_wr && (clr_cnt == LAST_CELL)) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
`else
    logic unused_clr;

    assign state      = IDLE;
    assign clr_wr     = 1'b0;
    assign clr_cnt    = '0;
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
    assign unused_clr = clr_req;
`endif

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb/tb_vram_scan_arbiter.sv - directed self-checking bench for vram_scan_arbiter

module tb_vram_scan_arbiter;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  h_addr = '0;
    logic [9:0]  v_addr = '0;
    logic        valid = 1'b0;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        clr_done;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [7:0]  char_code;
    logic [2:0]  cell_px;
    logic [3:0]  cell_py;
    logic        char_valid;

    int n_checks = 0;
    int n_fail = 0;

    vram_scan_arbiter_if #(.ADDR_W(12), .DATA_W(8)) wif ();

    vram_scan_arbiter dut (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .valid      (valid),
        .wr         (wif),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .char_code  (char_code),
        .cell_px    (cell_px),
        .cell_py    (cell_py),
        .char_valid (char_valid)
    );

    always #5 pclk = ~pclk;

    // VRAM model with a bench-side preload port.
    logic [7:0]  mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;
    int          we_cnt = 0;
    int          bad_slot = 0;
    logic [19:0] wlog [$];

    always @(posedge pclk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_cnt <= we_cnt + 1;
            wlog.push_back({ram_addr, ram_wdata});
            if (valid && h_addr[2:0] == 3'd0) bad_slot <= bad_slot + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int h, input int v, input bit vl);
        @(negedge pclk);
        h_addr = 10'(h);
        v_addr = 10'(v);
        valid  = vl;
        #1;
    endtask

    task automatic preload(input int a, input int d);
        @(negedge pclk);
        bd_we = 1'b1; bd_addr = 12'(a); bd_data = 8'(d);
        @(negedge pclk);
        bd_we = 1'b0;
    endtask

    task automatic do_write(input int a, input int d, output bit got);
        @(negedge pclk);
        wif.wr_req = 1'b1; wif.wr_addr = 12'(a); wif.wr_data = 8'(d);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge pclk); #1;
            if (wif.wr_ack) got = 1'b1;
        end
        wif.wr_req = 1'b0;
    endtask

    task automatic test_reset();
        wif.wr_req = 1'b0; wif.wr_addr = '0; wif.wr_data = '0;
        preload(81, 8'h41);
        preload(82, 8'h42);
        @(negedge pclk); #1;
        n_checks++; if (char_code !== 8'h00) begin n_fail++; $display("FAIL reset_char_code: got %h want 00", char_code); end
        n_checks++; if ({char_valid, cell_px, cell_py} !== 8'h00) begin n_fail++; $display("FAIL reset_cell: got %h want 00", {char_valid, cell_px, cell_py}); end
        n_checks++; if ({wif.wr_ack, ram_we, clr_busy, clr_done} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {wif.wr_ack, ram_we, clr_busy, clr_done}); end
        reset_n = 1'b1;
    endtask

    task automatic test_display();
        logic [7:0] exp_c;
        for (int h = 8; h <= 18; h++) begin
            drive(h, 16, 1'b1);
            if (h == 8) begin
                n_checks++; if (ram_addr !== 12'd81 || ram_we !== 1'b0) begin n_fail++; $display("FAIL disp_addr: got %0d we %b want 81 we 0", ram_addr, ram_we); end
            end
            if (h >= 10) begin
                exp_c = (h - 2 < 16) ? 8'h41 : 8'h42;
                n_checks++; if (char_code !== exp_c) begin n_fail++; $display("FAIL disp_char h=%0d: got %h want %h", h, char_code, exp_c); end
                n_checks++; if (cell_px !== 3'((h - 2) % 8) || cell_py !== 4'd0 || char_valid !== 1'b1) begin n_fail++; $display("FAIL disp_cell h=%0d: got px %0d py %0d v %b want px %0d py 0 v 1", h, cell_px, cell_py, char_valid, (h - 2) % 8); end
            end
        end
    endtask

    task automatic test_single_write();
        @(negedge pclk);
        valid = 1'b0;
        wif.wr_req = 1'b1; wif.wr_addr = 12'd5; wif.wr_data = 8'h5A;
        @(negedge pclk); #1;
        n_checks++; if (wif.wr_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b want 1", wif.wr_ack); end
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 12'd5 || ram_wdata !== 8'h5A) begin n_fail++; $display("FAIL single_drain: got we %b a %0d d %h want 1 5 5a", ram_we, ram_addr, ram_wdata); end
        wif.wr_req = 1'b0;
        @(negedge pclk); #1;
        n_checks++; if (wif.wr_ack !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL single_idle: got ack %b we %b want 0 0", wif.wr_ack, ram_we); end
        drive(40, 0, 1'b1);
        drive(41, 0, 1'b1);
        drive(42, 0, 1'b1);
        n_checks++; if (char_code !== 8'h5A) begin n_fail++; $display("FAIL single_readback: got %h want 5a", char_code); end
    endtask

    task automatic test_slot_collision();
        int we0;
        @(negedge pclk);
        h_addr = 10'd7; v_addr = 10'd0; valid = 1'b1;
        wif.wr_req = 1'b1; wif.wr_addr = 12'd77; wif.wr_data = 8'h77;
        #1; we0 = we_cnt;
        @(negedge pclk); h_addr = 10'd8; #1;
        n_checks++; if (wif.wr_ack !== 1'b1) begin n_fail++; $display("FAIL slot_ack: got %b want 1", wif.wr_ack); end
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== 12'd1) begin n_fail++; $display("FAIL slot_blocked: got we %b a %0d want 0 1", ram_we, ram_addr); end
        wif.wr_req = 1'b0;
        @(negedge pclk); h_addr = 10'd9; #1;
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 12'd77 || ram_wdata !== 8'h77) begin n_fail++; $display("FAIL slot_drain: got we %b a %0d d %h want 1 77 77", ram_we, ram_addr, ram_wdata); end
        @(negedge pclk); h_addr = 10'd10; #1;
        n_checks++; if (ram_we !== 1'b0 || we_cnt - we0 !== 1) begin n_fail++; $display("FAIL slot_once: got we %b count %0d want 0 1", ram_we, we_cnt - we0); end
    endtask

    task automatic test_back_to_back();
        int we0, acks;
        bit got;
        @(negedge pclk); valid = 1'b0;
        we0 = we_cnt; acks = 0;
        for (int i = 0; i < 10; i++) begin
            do_write(i, 8'h30 + i, got);
            if (got) acks++;
        end
        repeat (2) @(negedge pclk);
        n_checks++; if (acks !== 10) begin n_fail++; $display("FAIL b2b_acks: got %0d want 10", acks); end
        n_checks++; if (we_cnt - we0 !== 10) begin n_fail++; $display("FAIL b2b_writes: got %0d want 10", we_cnt - we0); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (mem[i] !== 8'(8'h30 + i)) begin n_fail++; $display("FAIL b2b_mem[%0d]: got %h want %h", i, mem[i], 8'(8'h30 + i)); end
        end
    endtask

    task automatic test_out_of_range();
        int we0;
        bit got;
        we0 = we_cnt;
        do_write(2400, 8'hEE, got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL oor_ack_2400: got %b want 1", got); end
        do_write(4095, 8'hEF, got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL oor_ack_4095: got %b want 1", got); end
        repeat (3) @(negedge pclk);
        n_checks++; if (we_cnt !== we0) begin n_fail++; $display("FAIL oor_no_write: got %0d writes want 0", we_cnt - we0); end
    endtask

`ifdef VRAM_CLEAR_EN
    task automatic test_clear();
        int ws, done_cnt, ack_busy, bad;
        bit finished;
        ws = wlog.size();
        @(negedge pclk);
        h_addr = 10'd7; v_addr = 10'd0; valid = 1'b1;
        wif.wr_req = 1'b1; wif.wr_addr = 12'd100; wif.wr_data = 8'h77;
        @(negedge pclk); h_addr = 10'd8; #1;
        n_checks++; if (wif.wr_ack !== 1'b1 || clr_busy !== 1'b0) begin n_fail++; $display("FAIL clr_pre: got ack %b busy %b want 1 0", wif.wr_ack, clr_busy); end
        wif.wr_req = 1'b0; clr_req = 1'b1;
        @(negedge pclk); h_addr = 10'd9; clr_req = 1'b0;
        wif.wr_req = 1'b1; wif.wr_addr = 12'd200; wif.wr_data = 8'h99; #1;
        n_checks++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_start: got %b want 1", clr_busy); end
        done_cnt = 0; ack_busy = 0; finished = 1'b0;
        for (int c = 0; c < 6000 && !finished; c++) begin
            @(negedge pclk);
            h_addr = 10'((10 + c) % 640); valid = (c < 300); #1;
            if (clr_done) done_cnt++;
            if (wif.wr_ack && clr_busy) ack_busy++;
            if (!clr_busy) finished = 1'b1;
        end
        n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL clr_timeout: busy still %b want 0", clr_busy); end
        n_checks++; if (done_cnt !== 1 || clr_done !== 1'b1) begin n_fail++; $display("FAIL clr_done: got %0d pulses now %b want 1 1", done_cnt, clr_done); end
        n_checks++; if (ack_busy !== 0) begin n_fail++; $display("FAIL clr_ack_busy: got %0d want 0", ack_busy); end
        @(negedge pclk); #1;
        n_checks++; if (wif.wr_ack !== 1'b1 || clr_done !== 1'b0) begin n_fail++; $display("FAIL clr_after: got ack %b done %b want 1 0", wif.wr_ack, clr_done); end
        wif.wr_req = 1'b0;
        @(negedge pclk);
        n_checks++; if (wlog.size() - ws !== 2402) begin n_fail++; $display("FAIL clr_count: got %0d writes want 2402", wlog.size() - ws); end
        if (wlog.size() - ws >= 2402) begin
            n_checks++; if (wlog[ws] !== {12'd100, 8'h77}) begin n_fail++; $display("FAIL clr_first: got %h want 06477", wlog[ws]); end
            bad = 0;
            for (int i = 0; i < 2400; i++) if (wlog[ws + 1 + i] !== {12'(i), 8'h20}) bad++;
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clr_sweep: got %0d wrong entries want 0", bad); end
            n_checks++; if (wlog[ws + 2401] !== {12'd200, 8'h99}) begin n_fail++; $display("FAIL clr_post_write: got %h want 0c899", wlog[ws + 2401]); end
        end
        // Reset in the middle of a sweep.
        @(negedge pclk); valid = 1'b0; clr_req = 1'b1;
        @(negedge pclk); clr_req = 1'b0;
        repeat (100) @(negedge pclk);
        #1;
        n_checks++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL clr_mid_busy: got %b want 1", clr_busy); end
        reset_n = 1'b0; #1;
        n_checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin n_fail++; $display("FAIL clr_abort: got busy %b done %b want 0 0", clr_busy, clr_done); end
        @(negedge pclk); reset_n = 1'b1;
        done_cnt = 0;
        repeat (30) begin @(negedge pclk); #1; if (clr_done || clr_busy) done_cnt++; end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL clr_no_done_after_reset: got %0d busy/done cycles want 0", done_cnt); end
    endtask
`else
    task automatic test_clear_disabled();
        int busy_cnt;
        bit got;
        @(negedge pclk); valid = 1'b0; clr_req = 1'b1;
        @(negedge pclk); clr_req = 1'b0;
        busy_cnt = 0;
        repeat (10) begin @(negedge pclk); #1; if (clr_busy || clr_done) busy_cnt++; end
        n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL noclr_busy: got %0d busy/done cycles want 0", busy_cnt); end
        do_write(300, 8'hC3, got);
        repeat (2) @(negedge pclk);
        n_checks++; if (got !== 1'b1 || mem[300] !== 8'hC3) begin n_fail++; $display("FAIL noclr_write: got ack %b mem %h want 1 c3", got, mem[300]); end
    endtask
`endif

    initial begin
        test_reset();
        test_display();
        test_single_write();
        test_slot_collision();
        test_back_to_back();
        test_out_of_range();
`ifdef VRAM_CLEAR_EN
        test_clear();
`else
        test_clear_disabled();
`endif
        n_checks++; if (bad_slot !== 0) begin n_fail++; $display("FAIL display_slot_writes: got %0d want 0", bad_slot); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
